// File: rtl/uart_rx.sv
// 8N1 UART receiver: oversampled start/data/stop detection with a valid/read
// handshake toward the host, plus sticky framing-error and overrun flags.
module uart_rx #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned P_9600      = 5208,
  parameter int unsigned P_115K      = 434,
  parameter int unsigned P_1M        = 50,
  parameter int unsigned P_4M        = 12
) (
  input  logic       uart_clock,
  input  logic       uart_reset,
  input  logic       uart_d_in,
  input  logic [1:0] freq_control,
  input  logic       uart_rx_read,
  output logic [7:0] uart_d_out,
  output logic       uart_rx_valid,
  output logic       uart_rx_busy,
  output logic       uart_frame_err,
  output logic       uart_overrun
);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StBreakWait
  } state_e;

  state_e state_q, state_d;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   rx_s;

  logic [12:0] clk_count_q, clk_count_d;
  logic [3:0]  bit_count_q, bit_count_d;
  logic [7:0]  shift_q, shift_d;
  logic [12:0] p_lat_q, p_lat_d;
  logic [12:0] p_sel;
  logic [12:0] half;

  logic [7:0] dout_q, dout_d;
  logic       valid_q, valid_d;
  logic       frame_err_q, frame_err_d;
  logic       overrun_q, overrun_d;

  logic       deliver;
  logic       frame_err_set;
  logic       rd_accept;

  // Reset to all 1s so a reset never looks like a start bit on the idle line.
  always_ff @(posedge uart_clock) begin
    if (uart_reset) begin
      sync_q <= '1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], uart_d_in};
    end
  end

  assign rx_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    p_sel = 13'(P_4M);
    unique case (freq_control)
      2'b00: p_sel = 13'(P_9600);
      2'b01: p_sel = 13'(P_115K);
      2'b10: p_sel = 13'(P_1M);
      2'b11: p_sel = 13'(P_4M);
      default: p_sel = 13'(P_4M);
    endcase
  end

  assign half = {1'b0, p_lat_q[12:1]};

  // Frame sequencing.
  always_comb begin
    state_d       = state_q;
    clk_count_d   = clk_count_q;
    bit_count_d   = bit_count_q;
    shift_d       = shift_q;
    p_lat_d       = p_lat_q;
    deliver       = 1'b0;
    frame_err_set = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!rx_s) begin
          p_lat_d     = p_sel;
          clk_count_d = '0;
          state_d     = StStart;
        end
      end

      StStart: begin
        if (clk_count_q == half) begin
          clk_count_d = '0;
          if (!rx_s) begin
            bit_count_d = '0;
            state_d     = StData;
          end else begin
            // Start bit not held through mid-bit: treat as a glitch.
            state_d = StIdle;
          end
        end else begin
          clk_count_d = clk_count_q + 13'd1;
        end
      end

      StData: begin
        if (clk_count_q == p_lat_q) begin
          shift_d     = {rx_s, shift_q[7:1]};
          clk_count_d = '0;
          bit_count_d = bit_count_q + 4'd1;
          if (bit_count_q == 4'd7) begin
            state_d = StStop;
          end
        end else begin
          clk_count_d = clk_count_q + 13'd1;
        end
      end

      StStop: begin
        if (clk_count_q == p_lat_q) begin
          clk_count_d = '0;
          if (rx_s) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            frame_err_set = 1'b1;
            state_d       = StBreakWait;
          end
        end else begin
          clk_count_d = clk_count_q + 13'd1;
        end
      end

      StBreakWait: begin
        // Hold off until the line returns high so a break is not re-read as starts.
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Host-side holding register and sticky flags.
  assign rd_accept = uart_rx_read & valid_q;

  always_comb begin
    dout_d      = dout_q;
    valid_d     = valid_q;
    frame_err_d = frame_err_q;
    overrun_d   = overrun_q;

    if (rd_accept) begin
      valid_d     = 1'b0;
      frame_err_d = 1'b0;
      overrun_d   = 1'b0;
    end

    if (deliver) begin
      dout_d  = shift_q;
      valid_d = 1'b1;
      if (valid_q && !uart_rx_read) begin
        overrun_d = 1'b1;
      end
    end

    if (frame_err_set) begin
      frame_err_d = 1'b1;
    end
  end

  always_ff @(posedge uart_clock) begin
    if (uart_reset) begin
      state_q     <= StIdle;
      clk_count_q <= '0;
      bit_count_q <= '0;
      shift_q     <= '0;
      p_lat_q     <= '0;
      dout_q      <= '0;
      valid_q     <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      clk_count_q <= clk_count_d;
      bit_count_q <= bit_count_d;
      shift_q     <= shift_d;
      p_lat_q     <= p_lat_d;
      dout_q      <= dout_d;
      valid_q     <= valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
    end
  end

  assign uart_d_out     = dout_q;
  assign uart_rx_valid  = valid_q;
  assign uart_rx_busy   = (state_q != StIdle);
  assign uart_frame_err = frame_err_q;
  assign uart_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of good frames plus hand-built sequences
// for glitch, framing error/break, read-on-deliver, baud switch and reset.
module tb_uart_rx;

  logic       uart_clock = 1'b0;
  logic       uart_reset;
  logic       uart_d_in;
  logic [1:0] freq_control;
  logic       uart_rx_read;
  logic [7:0] uart_d_out;
  logic       uart_rx_valid;
  logic       uart_rx_busy;
  logic       uart_frame_err;
  logic       uart_overrun;

  int checks = 0;
  int passed = 0;

  uart_rx dut (
    .uart_clock    (uart_clock),
    .uart_reset    (uart_reset),
    .uart_d_in     (uart_d_in),
    .freq_control  (freq_control),
    .uart_rx_read  (uart_rx_read),
    .uart_d_out    (uart_d_out),
    .uart_rx_valid (uart_rx_valid),
    .uart_rx_busy  (uart_rx_busy),
    .uart_frame_err(uart_frame_err),
    .uart_overrun  (uart_overrun)
  );

  always #5 uart_clock = ~uart_clock;

  typedef struct {
    logic [7:0] data;
    logic [7:0] exp_dout;
    logic       exp_ovr;
    int         exp_lat;
    logic       do_read;
  } vec_t;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // Drives one frame, one bit per bitc cycles; optional read/switch/reset pulses
  // at given cycle indices. vedge = edge number of the first valid rise, or -1.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int bitc,
                            input int rd_cyc, input int sw_cyc, input int rst_cyc,
                            output int vedge);
    logic [9:0] frame;
    logic       vprev;
    frame = {stop, b, 1'b0};
    vedge = -1;
    vprev = uart_rx_valid;
    for (int i = 0; i < 10 * bitc; i++) begin
      uart_d_in    = frame[i / bitc];
      uart_rx_read = (i == rd_cyc);
      uart_reset   = (i == rst_cyc);
      if (i == sw_cyc) freq_control = 2'b11;
      @(posedge uart_clock);
      #1;
      if (vedge < 0 && !vprev && uart_rx_valid) vedge = i + 1;
      vprev = uart_rx_valid;
    end
    uart_d_in    = 1'b1;
    uart_rx_read = 1'b0;
    uart_reset   = 1'b0;
  endtask

  task automatic pulse_read();
    uart_rx_read = 1'b1;
    @(posedge uart_clock);
    #1;
    uart_rx_read = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge uart_clock);
      #1;
    end
  endtask

  initial begin
    vec_t vecs[5];
    int   v;
    int   cnt;

    // Latency 127 edges = 2 synchronizer edges + 125 cycles from first rx_s low.
    vecs[0] = '{data: 8'hA5, exp_dout: 8'hA5, exp_ovr: 1'b0, exp_lat: 127, do_read: 1'b1};
    vecs[1] = '{data: 8'h11, exp_dout: 8'h11, exp_ovr: 1'b0, exp_lat: 127, do_read: 1'b0};
    vecs[2] = '{data: 8'h22, exp_dout: 8'h22, exp_ovr: 1'b1, exp_lat: -1,  do_read: 1'b1};
    vecs[3] = '{data: 8'h00, exp_dout: 8'h00, exp_ovr: 1'b0, exp_lat: 127, do_read: 1'b1};
    vecs[4] = '{data: 8'hFF, exp_dout: 8'hFF, exp_ovr: 1'b0, exp_lat: 127, do_read: 1'b0};

    uart_reset   = 1'b1;
    uart_d_in    = 1'b1;
    uart_rx_read = 1'b0;
    freq_control = 2'b11;
    idle_cycles(3);
    check("reset_dout", uart_d_out, 0);
    check("reset_valid", uart_rx_valid, 0);
    check("reset_busy", uart_rx_busy, 0);
    check("reset_ferr", uart_frame_err, 0);
    check("reset_ovr", uart_overrun, 0);
    uart_reset = 1'b0;
    idle_cycles(3);

    foreach (vecs[k]) begin
      send_frame(vecs[k].data, 1'b1, 13, -1, -1, -1, v);
      check($sformatf("vec%0d_dout", k), uart_d_out, vecs[k].exp_dout);
      check($sformatf("vec%0d_valid", k), uart_rx_valid, 1);
      check($sformatf("vec%0d_ovr", k), uart_overrun, vecs[k].exp_ovr);
      check($sformatf("vec%0d_ferr", k), uart_frame_err, 0);
      check($sformatf("vec%0d_busy", k), uart_rx_busy, 0);
      if (vecs[k].exp_lat >= 0) check($sformatf("vec%0d_latency", k), v, vecs[k].exp_lat);
      if (vecs[k].do_read) begin
        pulse_read();
        check($sformatf("vec%0d_read_valid", k), uart_rx_valid, 0);
        check($sformatf("vec%0d_read_ovr", k), uart_overrun, 0);
      end
    end

    // Read asserted on the exact cycle the next byte is delivered.
    send_frame(8'h6B, 1'b1, 13, 126, -1, -1, v);
    check("rod_valid", uart_rx_valid, 1);
    check("rod_dout", uart_d_out, 8'h6B);
    check("rod_ovr", uart_overrun, 0);
    pulse_read();
    check("rod_read_valid", uart_rx_valid, 0);

    // Four-cycle low glitch.
    cnt = 0;
    for (int i = 0; i < 20; i++) begin
      uart_d_in = (i < 4) ? 1'b0 : 1'b1;
      @(posedge uart_clock);
      #1;
      if (uart_rx_busy) cnt++;
    end
    check("glitch_busy_cycles", cnt, 7);
    check("glitch_valid", uart_rx_valid, 0);
    check("glitch_ferr", uart_frame_err, 0);
    check("glitch_busy_end", uart_rx_busy, 0);

    // Bad stop bit followed by a held-low line.
    send_frame(8'h3C, 1'b0, 13, -1, -1, -1, v);
    check("ferr_flag", uart_frame_err, 1);
    check("ferr_no_valid_edge", v, -1);
    cnt = 0;
    uart_d_in = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(posedge uart_clock);
      #1;
      if (uart_rx_busy) cnt++;
    end
    check("break_busy_cycles", cnt, 50);
    check("break_valid", uart_rx_valid, 0);
    uart_d_in = 1'b1;
    idle_cycles(5);
    check("break_release_busy", uart_rx_busy, 0);
    send_frame(8'h81, 1'b1, 13, -1, -1, -1, v);
    check("after_break_dout", uart_d_out, 8'h81);
    check("after_break_valid", uart_rx_valid, 1);
    check("after_break_ferr_sticky", uart_frame_err, 1);
    pulse_read();
    check("after_break_read_ferr", uart_frame_err, 0);
    check("after_break_read_valid", uart_rx_valid, 0);

    // 115k frame with freq_control switched to 4M partway through.
    freq_control = 2'b01;
    idle_cycles(2);
    send_frame(8'h5A, 1'b1, 435, -1, 1000, -1, v);
    check("baud_dout", uart_d_out, 8'h5A);
    check("baud_valid", uart_rx_valid, 1);
    check("baud_latency", v, 4136);

    // Reset during data bit 4; byte 0x5A still held so clearing is observable.
    send_frame(8'hF0, 1'b1, 13, -1, -1, 70, v);
    check("rst_no_delivery", v, -1);
    check("rst_valid", uart_rx_valid, 0);
    check("rst_dout", uart_d_out, 0);
    check("rst_busy", uart_rx_busy, 0);
    check("rst_ferr", uart_frame_err, 0);
    check("rst_ovr", uart_overrun, 0);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
